// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_pkg
// Brief    : Shared types and helpers for the adder request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_req_arbiter_if
// Brief    : Request, response and adder-datapath bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_req_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_grant;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_carry;
    logic                      rsp_err;

    logic [DATA_W-1:0]         Value_a;
    logic [DATA_W-1:0]         Value_b;
    logic                      Data_val;
    logic [DATA_W-1:0]         Sum_result;
    logic                      Sum_carry;
    logic                      Data_ready;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready,
        input  Sum_result, Sum_carry, Data_ready,
        output req_grant, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err,
        output Value_a, Value_b, Data_val
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready,
        output Sum_result, Sum_carry, Data_ready,
        input  req_grant, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err,
        input  Value_a, Value_b, Data_val
    );

endinterface
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Brief    : Combinational round-robin picker starting the search at rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_req
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int k;
            k = int'(rr_ptr) + off;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_req_arbiter
// Brief    : Round-robin sharing of one 8-bit adder among NUM_REQ requesters,
//            with timeout. Optional stats counters via ADDER_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adder_req_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    adder_req_arbiter_if.master  bus,
    output logic                 busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]          stat_grants,
    output logic [7:0]           stat_timeouts
`endif
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     sel;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]    wait_cnt_next;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                any_req;
    logic                timed_out;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    assign wait_cnt_next = wait_cnt + CNT_W'(1);
    assign timed_out     = (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            sel           <= '0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            bus.req_grant <= '0;
            bus.Data_val  <= 1'b0;
            bus.Value_a   <= '0;
            bus.Value_b   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.req_grant <= '0;
            bus.Data_val  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.req_grant <= pick_grant;
                        bus.Data_val  <= 1'b1;
                        bus.Value_a   <= bus.req_a[pick_idx*DATA_W +: DATA_W];
                        bus.Value_b   <= bus.req_b[pick_idx*DATA_W +: DATA_W];
                        sel           <= pick_idx;
                        wait_cnt      <= '0;
                        busy          <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt_next;
                    // A result arriving on the timeout cycle still counts as a result.
                    if (bus.Data_ready) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= sel;
                        bus.rsp_sum   <= bus.Sum_result;
                        bus.rsp_carry <= bus.Sum_carry;
                        bus.rsp_err   <= 1'b0;
                        state         <= RESP;
                    end else if (timed_out) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= sel;
                        bus.rsp_sum   <= '0;
                        bus.rsp_carry <= 1'b0;
                        bus.rsp_err   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        rr_ptr        <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic grant_evt;
    logic timeout_evt;

    assign grant_evt   = (state == IDLE) && any_req;
    assign timeout_evt = (state == WAIT) && !bus.Data_ready && timed_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grants   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (grant_evt && (stat_grants != '1)) begin
                stat_grants <= stat_grants + 16'd1;
            end
            if (timeout_evt && (stat_timeouts != '1)) begin
                stat_timeouts <= stat_timeouts + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
